// File: rtl/aes_pkg.sv
// Shared AES round-datapath types and helpers: FSM states, reduction constant,
// xtime, and byte/column indexing for the 128-bit state layout.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] AES_POLY = 8'h1B;

  // Multiply by x in GF(2^8); carry-out of the shift is folded back via poly.
  function automatic logic [7:0] xtime(input logic [7:0] x, input logic [7:0] poly);
    return {x[6:0], 1'b0} ^ (x[7] ? poly : 8'h00);
  endfunction

  // Byte k sits at the top of the word: byte 0 is bits [127:120].
  function automatic logic [3:0] byte_idx(input logic [1:0] col, input logic [1:0] row);
    return {col, row};
  endfunction

  function automatic logic [7:0] get_byte(input logic [127:0] s, input logic [3:0] k);
    return s[127 - 8*int'(k) -: 8];
  endfunction

  function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
    return s[127 - 32*int'(c) -: 32];
  endfunction

  function automatic logic [127:0] set_col(input logic [127:0] s, input logic [1:0] c,
                                           input logic [31:0] v);
    logic [127:0] r;
    r = s;
    r[127 - 32*int'(c) -: 32] = v;
    return r;
  endfunction

endpackage

// File: rtl/mixcolumns_col.sv
// Combinational MixColumns of one column (four bytes in, four bytes out).
// Zero latency; no flow control of its own.
module mixcolumns_col
  import aes_pkg::*;
#(
  parameter logic [7:0] polynomial = 8'b00011011
) (
  input  logic [7:0] s0,
  input  logic [7:0] s1,
  input  logic [7:0] s2,
  input  logic [7:0] s3,
  output logic [7:0] o0,
  output logic [7:0] o1,
  output logic [7:0] o2,
  output logic [7:0] o3
);

  logic [7:0] d0, d1, d2, d3;

  assign d0 = xtime(s0, polynomial);
  assign d1 = xtime(s1, polynomial);
  assign d2 = xtime(s2, polynomial);
  assign d3 = xtime(s3, polynomial);

  // 3*x is written as 2*x ^ x
  assign o0 = d0 ^ (d1 ^ s1) ^ s2 ^ s3;
  assign o1 = s0 ^ d1 ^ (d2 ^ s2) ^ s3;
  assign o2 = s0 ^ s1 ^ d2 ^ (d3 ^ s3);
  assign o3 = (d0 ^ s0) ^ s1 ^ s2 ^ d3;

endmodule

// File: rtl/mixcolumns_sequencer.sv
// Column-serial MixColumns: 5-cycle latency, one state per 6 cycles; result held until IN_ready,
// input accepted only when idle. Optional final-round bypass under MIXCOL_BYPASS_EN.
module mixcolumns_sequencer
  import aes_pkg::*;
#(
  parameter logic [7:0] polynomial = 8'b00011011
) (
  input  logic         IN_clk,
  input  logic         IN_rst,
  input  logic         IN_valid,
  output logic         OUT_ready,
  input  logic [127:0] IN_state,
`ifdef MIXCOL_BYPASS_EN
  input  logic         IN_bypass,
`endif
  output logic         OUT_valid,
  input  logic         IN_ready,
  output logic [127:0] OUT_state,
  output logic         OUT_busy
);

  state_t       state_q, state_d;
  logic [1:0]   col_q;
  logic [127:0] src_q;
  logic [127:0] res_q;
  logic [31:0]  src_col;
  logic [31:0]  mix_col;
  logic [31:0]  wr_col;
`ifdef MIXCOL_BYPASS_EN
  logic         byp_q;
`endif

  assign src_col = get_col(src_q, col_q);

  mixcolumns_col #(
    .polynomial(polynomial)
  ) u_col (
    .s0(src_col[31:24]),
    .s1(src_col[23:16]),
    .s2(src_col[15:8]),
    .s3(src_col[7:0]),
    .o0(mix_col[31:24]),
    .o1(mix_col[23:16]),
    .o2(mix_col[15:8]),
    .o3(mix_col[7:0])
  );

`ifdef MIXCOL_BYPASS_EN
  assign wr_col = byp_q ? src_col : mix_col;
`else
  assign wr_col = mix_col;
`endif

  always_ff @(posedge IN_clk) begin
    if (IN_rst) begin
      state_q <= IDLE;
      col_q   <= 2'd0;
      src_q   <= '0;
      res_q   <= '0;
`ifdef MIXCOL_BYPASS_EN
      byp_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (IN_valid) begin
            src_q <= IN_state;
            col_q <= 2'd0;
`ifdef MIXCOL_BYPASS_EN
            byp_q <= IN_bypass;
`endif
          end
        end
        RUN: begin
          res_q <= set_col(res_q, col_q, wr_col);
          col_q <= col_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    OUT_ready = 1'b0;
    OUT_valid = 1'b0;
    OUT_busy  = 1'b0;
    case (state_q)
      IDLE: begin
        OUT_ready = 1'b1;
        if (IN_valid) state_d = RUN;
      end
      RUN: begin
        OUT_busy = 1'b1;
        if (col_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        OUT_busy  = 1'b1;
        OUT_valid = 1'b1;
        if (IN_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign OUT_state = res_q;

endmodule

// File: tb/tb_mixcolumns_sequencer.sv
// Directed bench for mixcolumns_sequencer: FIPS-197 vectors, latency, backpressure,
// mid-run reset and (with MIXCOL_BYPASS_EN) bypass.
module tb_mixcolumns_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_state;
`ifdef MIXCOL_BYPASS_EN
  logic         in_bypass;
`endif
  logic         out_valid;
  logic         in_ready;
  logic [127:0] out_state;
  logic         out_busy;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] V1_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V1_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] V2_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  always #5 clk = ~clk;

  mixcolumns_sequencer dut (
    .IN_clk   (clk),
    .IN_rst   (rst),
    .IN_valid (in_valid),
    .OUT_ready(out_ready),
    .IN_state (in_state),
`ifdef MIXCOL_BYPASS_EN
    .IN_bypass(in_bypass),
`endif
    .OUT_valid(out_valid),
    .IN_ready (in_ready),
    .OUT_state(out_state),
    .OUT_busy (out_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a state, take the handshake edge, then apply the hold values and
  // count edges until OUT_valid (the handshake edge counts as 1).
  task automatic send(input logic [127:0] s, input logic hold_valid,
                      input logic [127:0] hold_state, output int n);
    in_valid = 1'b1;
    in_state = s;
    tick();
    n = 1;
    in_valid = hold_valid;
    in_state = hold_state;
    while (out_valid !== 1'b1 && n < 30) begin
      tick();
      n++;
    end
  endtask

  int lat;
  logic seen;

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_state = V1_IN;
    in_ready = 1'b0;
`ifdef MIXCOL_BYPASS_EN
    in_bypass = 1'b0;
`endif
    repeat (3) tick();
    chk("rst_ready", 128'(out_ready), 128'd1);
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_busy",  128'(out_busy),  128'd0);
    chk("rst_state", out_state, 128'd0);

    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("post_rst_no_capture", 128'(out_busy), 128'd0);

    // FIPS-197 vector, then stall in DONE while a second state is offered
    send(V1_IN, 1'b0, 128'd0, lat);
    chk("v1_latency", 128'(lat), 128'd5);
    chk("v1_state",   out_state, V1_OUT);
    in_valid = 1'b1;
    in_state = V2_IN;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_state", out_state, V1_OUT);
      chk("hold_ready", 128'(out_ready), 128'd0);
      chk("hold_valid", 128'(out_valid), 128'd1);
    end

    // Output handshake with IN_valid also high: only the handshake takes effect
    in_ready = 1'b1;
    tick();
    chk("hs_ready", 128'(out_ready), 128'd1);
    chk("hs_valid", 128'(out_valid), 128'd0);
    in_ready = 1'b0;

    // Second state accepted in the very next cycle; a competing IN_valid during RUN is ignored
    send(V2_IN, 1'b1, V1_IN, lat);
    chk("v2_latency", 128'(lat), 128'd5);
    chk("v2_state",   out_state, V2_OUT);
    in_valid = 1'b0;
    in_ready = 1'b1;
    tick();
    chk("v2_drain", 128'(out_busy), 128'd0);
    in_ready = 1'b0;

    // Reset while col_q = 2 discards the in-flight state
    in_valid = 1'b1;
    in_state = V1_IN;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("pre_abort_busy", 128'(out_busy), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_state", out_state, 128'd0);
    chk("abort_ready", 128'(out_ready), 128'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_valid", 128'(seen), 128'd0);

    in_ready = 1'b1;
    send(V2_IN, 1'b0, 128'd0, lat);
    chk("after_abort_latency", 128'(lat), 128'd5);
    chk("after_abort_state",   out_state, V2_OUT);
    tick();

`ifdef MIXCOL_BYPASS_EN
    in_bypass = 1'b1;
    send(V1_IN, 1'b0, 128'd0, lat);
    in_bypass = 1'b0;
    chk("byp_latency", 128'(lat), 128'd5);
    chk("byp_state",   out_state, V1_IN);
    tick();
    send(V1_IN, 1'b0, 128'd0, lat);
    chk("nobyp_latency", 128'(lat), 128'd5);
    chk("nobyp_state",   out_state, V1_OUT);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
